// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destinations in E/M/W, decides D-stage stalls,
// selects D- and E-operand forwarding sources, and counts down multiply/divide occupancy.
module hazard_scoreboard #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned TW          = 2,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TW-1:0]     d_tuse_rs,
    input  logic [TW-1:0]     d_tuse_rt,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [TW-1:0]     d_tnew,
    input  logic              d_md_use,
    input  logic              d_md_start,
    input  logic              d_md_is_div,
    output logic              stall,
    output logic [1:0]        fwd_d_rs,
    output logic [1:0]        fwd_d_rt,
    output logic [1:0]        fwd_e_rs,
    output logic [1:0]        fwd_e_rt,
    output logic              md_busy
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    logic [REG_AW-1:0] e_dst_q, e_rs_q, e_rt_q, m_dst_q, w_dst_q;
    logic [TW-1:0]     e_tnew_q, m_tnew_q, w_tnew_q;
    logic              e_md_start_q, e_md_is_div_q;
    logic [CW-1:0]     md_cnt_q, md_cnt_d;
    logic              data_hit, md_hit, issue;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Producer in a stage will not have its result ready by the time the consumer needs it.
    function automatic logic late(input logic [REG_AW-1:0] sdst, input logic [TW-1:0] stnew,
                                  input logic [REG_AW-1:0] src, input logic [TW-1:0] tuse);
        return (sdst == src) && (sdst != '0) && (stnew > tuse);
    endfunction

    // Nearest matching stage wins; a match that is not ready yet blocks the older stage.
    function automatic logic [1:0] pick(input logic [REG_AW-1:0] src,
                                        input logic [REG_AW-1:0] near_dst,
                                        input logic [TW-1:0]     near_tnew,
                                        input logic [REG_AW-1:0] far_dst,
                                        input logic [TW-1:0]     far_tnew);
        if ((near_dst == src) && (near_dst != '0)) begin
            return (near_tnew == '0) ? 2'd1 : 2'd0;
        end else if ((far_dst == src) && (far_dst != '0)) begin
            return (far_tnew == '0) ? 2'd2 : 2'd0;
        end
        return 2'd0;
    endfunction

    assign data_hit = late(e_dst_q, e_tnew_q, d_rs, d_tuse_rs)
                    | late(m_dst_q, m_tnew_q, d_rs, d_tuse_rs)
                    | late(w_dst_q, w_tnew_q, d_rs, d_tuse_rs)
                    | late(e_dst_q, e_tnew_q, d_rt, d_tuse_rt)
                    | late(m_dst_q, m_tnew_q, d_rt, d_tuse_rt)
                    | late(w_dst_q, w_tnew_q, d_rt, d_tuse_rt);

    assign md_busy = (md_cnt_q != '0);
    assign md_hit  = d_md_use & (e_md_start_q | md_busy);
    assign stall   = d_valid & (data_hit | md_hit);
    assign issue   = d_valid & ~stall;

    assign fwd_d_rs = d_valid ? pick(d_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q) : 2'd0;
    assign fwd_d_rt = d_valid ? pick(d_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q) : 2'd0;
    assign fwd_e_rs = pick(e_rs_q, m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
    assign fwd_e_rt = pick(e_rt_q, m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);

    // A new start overwrites any count still running.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_md_start_q) begin
            md_cnt_d = e_md_is_div_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_dst_q       <= '0;
            e_tnew_q      <= '0;
            e_rs_q        <= '0;
            e_rt_q        <= '0;
            e_md_start_q  <= 1'b0;
            e_md_is_div_q <= 1'b0;
            m_dst_q       <= '0;
            m_tnew_q      <= '0;
            w_dst_q       <= '0;
            w_tnew_q      <= '0;
            md_cnt_q      <= '0;
        end else begin
            if (issue) begin
                e_dst_q       <= d_dst;
                e_tnew_q      <= d_tnew;
                e_rs_q        <= d_rs;
                e_rt_q        <= d_rt;
                e_md_start_q  <= d_md_start;
                e_md_is_div_q <= d_md_is_div;
            end else begin
                e_dst_q       <= '0;
                e_tnew_q      <= '0;
                e_rs_q        <= '0;
                e_rt_q        <= '0;
                e_md_start_q  <= 1'b0;
                e_md_is_div_q <= 1'b0;
            end
            m_dst_q  <= e_dst_q;
            m_tnew_q <= sat_dec(e_tnew_q);
            w_dst_q  <= m_dst_q;
            w_tnew_q <= sat_dec(m_tnew_q);
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic, all checked
// against an instruction-history reference model.
module tb_hazard_scoreboard;

    localparam int REG_AW      = 5;
    localparam int TW          = 2;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              d_valid;
    logic [REG_AW-1:0] d_rs, d_rt, d_dst;
    logic [TW-1:0]     d_tuse_rs, d_tuse_rt, d_tnew;
    logic              d_md_use, d_md_start, d_md_is_div;
    logic              stall, md_busy;
    logic [1:0]        fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_AW      (REG_AW),
        .TW          (TW),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .d_valid     (d_valid),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_dst       (d_dst),
        .d_tnew      (d_tnew),
        .d_md_use    (d_md_use),
        .d_md_start  (d_md_start),
        .d_md_is_div (d_md_is_div),
        .stall       (stall),
        .fwd_d_rs    (fwd_d_rs),
        .fwd_d_rt    (fwd_d_rt),
        .fwd_e_rs    (fwd_e_rs),
        .fwd_e_rt    (fwd_e_rt),
        .md_busy     (md_busy)
    );

    // pipe[k] is the instruction that entered E k edges ago (tnew as it was on entry).
    typedef struct {
        int dst;
        int tnew;
        int rs;
        int rt;
        bit md_start;
        bit is_div;
    } entry_t;

    entry_t pipe[3];
    int     cyc, md_end;
    int     nchecks, nfail;
    bit     exp_stall;
    int     obs_stall, obs_fwd_d_rs, obs_fwd_e_rs, obs_busy;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int tnew_at(input int k);
        return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
    endfunction

    task automatic model_d(input int src, input int tuse, output bit st, output int fwd);
        bit found;
        st = 0; fwd = 0; found = 0;
        for (int k = 0; k < 3; k++)
            if (src != 0 && pipe[k].dst == src && tnew_at(k) > tuse) st = 1;
        for (int k = 0; k < 2; k++)
            if (!found && src != 0 && pipe[k].dst == src) begin
                found = 1;
                fwd = (tnew_at(k) == 0) ? k + 1 : 0;
            end
    endtask

    function automatic int model_e(input int src);
        for (int k = 1; k < 3; k++)
            if (src != 0 && pipe[k].dst == src) return (tnew_at(k) == 0) ? k : 0;
        return 0;
    endfunction

    task automatic cycle();
        bit st_rs, st_rt, md;
        int f_rs, f_rt;
        @(negedge clk);
        model_d(int'(d_rs), int'(d_tuse_rs), st_rs, f_rs);
        model_d(int'(d_rt), int'(d_tuse_rt), st_rt, f_rt);
        md = d_md_use && (pipe[0].md_start || cyc < md_end);
        exp_stall = d_valid && (st_rs || st_rt || md);
        check_val("stall", stall, exp_stall);
        check_val("fwd_d_rs", fwd_d_rs, d_valid ? f_rs : 0);
        check_val("fwd_d_rt", fwd_d_rt, d_valid ? f_rt : 0);
        check_val("fwd_e_rs", fwd_e_rs, model_e(pipe[0].rs));
        check_val("fwd_e_rt", fwd_e_rt, model_e(pipe[0].rt));
        check_val("md_busy", md_busy, cyc < md_end);
        obs_stall = stall; obs_fwd_d_rs = fwd_d_rs; obs_fwd_e_rs = fwd_e_rs; obs_busy = md_busy;
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
            md_end = 0;
        end else begin
            entry_t n;
            if (pipe[0].md_start)
                md_end = cyc + 1 + (pipe[0].is_div ? DIV_CYCLES : MULT_CYCLES);
            n = '{default: 0};
            if (d_valid && !exp_stall)
                n = '{dst: int'(d_dst), tnew: int'(d_tnew), rs: int'(d_rs), rt: int'(d_rt),
                      md_start: d_md_start, is_div: d_md_is_div};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = n;
        end
        cyc++;
        #1;
    endtask

    task automatic set_d(input bit v, input int rs, input int tuse_rs, input int rt,
                         input int tuse_rt, input int dst, input int tnew,
                         input bit md_use, input bit md_start, input bit is_div);
        d_valid = v; d_rs = REG_AW'(rs); d_tuse_rs = TW'(tuse_rs);
        d_rt = REG_AW'(rt); d_tuse_rt = TW'(tuse_rt);
        d_dst = REG_AW'(dst); d_tnew = TW'(tnew);
        d_md_use = md_use; d_md_start = md_start; d_md_is_div = is_div;
    endtask

    task automatic idle(input int n);
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) cycle();
    endtask

    // Cycles the current D instruction until it stops stalling; returns stall count.
    task automatic run_until_free(input int limit, output int nst);
        nst = 0;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (obs_stall != 0) nst++;
            else break;
        end
    endtask

    int nst;

    initial begin
        nchecks = 0; nfail = 0; cyc = 0; md_end = 0;
        for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
        reset = 1'b1;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        check_val("reset_stall", obs_stall, 0);
        check_val("reset_busy", obs_busy, 0);
        check_val("reset_fwd_e", obs_fwd_e_rs, 0);

        // load-use
        set_d(1, 0, 3, 0, 3, 1, 2, 0, 0, 0); cycle();
        set_d(1, 1, 1, 0, 3, 0, 0, 0, 0, 0); run_until_free(10, nst);
        check_val("loaduse_stalls", nst, 1);
        idle(1);
        check_val("loaduse_fwd_e_rs", obs_fwd_e_rs, 2);
        idle(3);

        // ALU result to branch in D
        set_d(1, 0, 3, 0, 3, 3, 1, 0, 0, 0); cycle();
        set_d(1, 3, 0, 0, 3, 0, 0, 0, 0, 0); run_until_free(10, nst);
        check_val("branch_stalls", nst, 1);
        check_val("branch_fwd_d_rs", obs_fwd_d_rs, 2);
        idle(3);

        // younger stage wins
        set_d(1, 0, 3, 0, 3, 5, 0, 0, 0, 0); cycle();
        set_d(1, 0, 3, 0, 3, 5, 0, 0, 0, 0); cycle();
        set_d(1, 5, 1, 0, 3, 0, 0, 0, 0, 0); cycle();
        check_val("younger_fwd", obs_fwd_d_rs, 1);
        idle(3);
        set_d(1, 0, 3, 0, 3, 5, 0, 0, 0, 0); cycle();
        set_d(1, 0, 3, 0, 3, 5, 1, 0, 0, 0); cycle();
        set_d(1, 5, 1, 0, 3, 0, 0, 0, 0, 0); cycle();
        check_val("younger_notready_fwd", obs_fwd_d_rs, 0);
        check_val("younger_notready_stall", obs_stall, 0);
        idle(3);

        // zero register never hazards
        set_d(1, 0, 3, 0, 3, 0, 2, 0, 0, 0); cycle();
        set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        check_val("zero_stall", obs_stall, 0);
        check_val("zero_fwd", obs_fwd_d_rs, 0);
        idle(3);

        // divide then mflo, multiply then mflo
        set_d(1, 0, 3, 0, 3, 0, 0, 1, 1, 1); cycle();
        set_d(1, 0, 3, 0, 3, 2, 1, 1, 0, 0); run_until_free(30, nst);
        check_val("div_stalls", nst, DIV_CYCLES + 1);
        check_val("div_busy_after", obs_busy, 0);
        idle(3);
        set_d(1, 0, 3, 0, 3, 0, 0, 1, 1, 0); cycle();
        set_d(1, 0, 3, 0, 3, 2, 1, 1, 0, 0); run_until_free(30, nst);
        check_val("mult_stalls", nst, MULT_CYCLES + 1);
        idle(3);

        // reset in the middle of a divide
        set_d(1, 0, 3, 0, 3, 4, 0, 1, 1, 1); cycle();
        idle(4);
        check_val("div_running", obs_busy, 1);
        reset = 1'b1; cycle(); reset = 1'b0;
        set_d(1, 4, 0, 4, 0, 0, 0, 1, 0, 0); cycle();
        check_val("midreset_busy", obs_busy, 0);
        check_val("midreset_stall", obs_stall, 0);
        check_val("midreset_fwd_d", obs_fwd_d_rs, 0);
        check_val("midreset_fwd_e", obs_fwd_e_rs, 0);
        idle(2);

        // random traffic on a small register set to provoke frequent matches
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_d($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 1));
            cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5, register-number width; number 0 is the hardwired zero register.
REQ-002 Parameter TW, default 2, width of every T_use / T_new field.
REQ-003 Parameter MULT_CYCLES, default 5, busy cycles after a multiply start.
REQ-004 Parameter DIV_CYCLES, default 10, busy cycles after a divide start.
REQ-005 Ports, in order:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- d_valid  in  1  D holds a real instruction; 0 means bubble.
- d_rs, d_rt  in  REG_AW each  D source registers.
- d_tuse_rs, d_tuse_rt  in  TW each  cycles until D needs each source.
- d_dst  in  REG_AW  D destination register; 0 means no write.
- d_tnew  in  TW  cycles until the result exists, counted from stage E.
- d_md_use  in  1  D instruction touches the MD unit (mult/div/mfhi/mflo/mthi/mtlo).
- d_md_start  in  1  D instruction starts a multiply or divide.
- d_md_is_div  in  1  the started operation is a divide.
- stall  out  1  freeze F/D and insert a bubble into E.
- fwd_d_rs, fwd_d_rt  out  2 each  D-operand source: 0 = RF, 1 = E, 2 = M.
- fwd_e_rs, fwd_e_rt  out  2 each  E-operand source: 0 = pipe register, 1 = M, 2 = W.
- md_busy  out  1  MD countdown is non-zero.

Function
REQ-006 Tracking registers: E stage holds {dst, tnew, rs, rt, md_start, md_is_div}; M stage holds {dst, tnew}; W stage holds {dst, tnew}.
REQ-007 On each edge when stall=0 and d_valid=1, the E entry loads the D fields; when stall=1 or d_valid=0, the E entry loads a bubble (dst=0, tnew=0, rs=0, rt=0, md_start=0).
REQ-008 On every edge, M loads E with tnew = max(E.tnew-1, 0), and W loads M with tnew = max(M.tnew-1, 0).
REQ-009 Data-stall term for stage S in {E, M, W} and source x in {rs, rt}: S.dst==d_x AND S.dst!=0 AND S.tnew > d_tuse_x.
REQ-010 MD-stall term: d_valid AND d_md_use AND (E.md_start OR md_busy).
REQ-011 stall is the combinational OR of all data-stall terms and the MD-stall term, all qualified by d_valid.
REQ-012 fwd_d_x selects the nearest matching stage (E before M) whose dst equals d_x, with dst!=0.
- The matched stage is used only if its tnew==0; otherwise fwd_d_x=0.
- An older stage is never selected when a younger stage matches.
REQ-013 fwd_e_x applies the same nearest-match rule to E.x against M then W, with the same tnew==0 qualification.
REQ-014 MD countdown, width ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)), updated each edge:
- If E.md_start=1, load DIV_CYCLES when E.md_is_div=1, else MULT_CYCLES.
- Otherwise, if non-zero, decrement by 1.
- Otherwise, hold 0.
REQ-015 md_busy is 1 exactly when the countdown is non-zero; a load while already busy overwrites the count.
REQ-016 All outputs are combinational from the tracking state and the D inputs; there is no extra output latency.
REQ-017 When d_valid=0: stall=0 and fwd_d_rs=fwd_d_rt=0, and the tracking state still advances per REQ-007 and REQ-008.

Reset
REQ-018 When reset=1 at an edge, every tracking field and the MD countdown clear to 0, overriding REQ-007, REQ-008 and REQ-014 in that cycle, including mid-countdown.
REQ-019 In the cycle after reset with d_valid=0: stall=0, md_busy=0, and all fwd outputs are 0.

Verification
REQ-020 Load-use: issue dst=1, tnew=2, then src rs=1, tuse=1.
- stall=1 for exactly 1 cycle.
- The consumer then enters E with fwd_e_rs=2 (W).
REQ-021 ALU-to-branch: issue dst=3, tnew=1, then rs=3, tuse=0.
- stall=1 for 1 cycle.
- Then fwd_d_rs=2 (M) with stall=0.
REQ-022 Younger wins: E.dst=5, tnew=0 and M.dst=5, tnew=0, with D rs=5 -> fwd_d_rs=1; set E.tnew=1 with tuse=1 -> fwd_d_rs=0, stall=0.
REQ-023 Zero register: producer dst=0, tnew=2, then rs=0, tuse=0 -> stall=0, fwd_d_rs=0.
REQ-024 Divide: issue a divide start, then mflo (d_md_use=1) directly behind it.
- stall=1 for DIV_CYCLES+1 cycles (E.md_start cycle plus 10 busy).
- md_busy falls after 10 cycles.
- Repeat with a multiply: stall for 6 cycles.
REQ-025 Reset mid-countdown: assert reset 3 cycles into a divide -> next cycle md_busy=0, stall=0, all fwd outputs 0.
